alu_class_wf_arbiter: RTL and testbench

- Per-FU-class wavefront arbiter in the issue stage; one instance per class (SIMD, SIMF, LSU, SALU).
- Picks one ready wavefront per cycle from a request vector, round-robin. Drives the class's wf_valid/wf_choosen pair into the ALU issue logic.
- Holds its pick stable until the issue logic issues it or the request drops.
- After an issue, masks that wavefront for a programmable lockout window so it is not re-picked before its scoreboard/busy state updates.

---
 rtl/alu_class_wf_arbiter_if.sv | 32 +++
 rtl/alu_class_wf_arbiter.sv | 115 +++++++++++
 tb/tb_alu_class_wf_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_class_wf_arbiter_if.sv
// Issue-stage bundle between the ALU issue logic and one per-class
// wavefront arbiter.
//   req_valid      : per-wavefront ready-for-this-class request
//   class_selected : issue logic selected this class this cycle
//   c_issued_valid : issue logic issued an instruction this cycle
//   c_issued_wfid  : wavefront id issued this cycle
//   wf_valid       : registered, wf_chosen is a valid candidate
//   wf_chosen      : registered candidate wavefront id
//   issue_ack      : combinational, the held candidate was issued this cycle
// master = issue logic side, slave = arbiter side.
interface alu_class_wf_arbiter_if #(
  parameter int NUM_WF       = 40,
  parameter int WF_ID_LENGTH = 6
);
  logic [NUM_WF-1:0]       req_valid;
  logic                    class_selected;
  logic                    c_issued_valid;
  logic [WF_ID_LENGTH-1:0] c_issued_wfid;
  logic                    wf_valid;
  logic [WF_ID_LENGTH-1:0] wf_chosen;
  logic                    issue_ack;

  modport master (
    output req_valid, class_selected, c_issued_valid, c_issued_wfid,
    input  wf_valid, wf_chosen, issue_ack
  );

  modport slave (
    input  req_valid, class_selected, c_issued_valid, c_issued_wfid,
    output wf_valid, wf_chosen, issue_ack
  );
endinterface

// File: rtl/alu_class_wf_arbiter.sv
// Per-FU-class wavefront arbiter. Picks one ready wavefront per cycle
// round-robin, holds the pick until it is issued or its request drops,
// and locks an issued wavefront out for LOCKOUT extra cycles so it is not
// re-picked before its scoreboard/busy state catches up.
// Ports:
//   clk : clock
//   rst : synchronous reset, active low
//   arb : alu_class_wf_arbiter_if.slave (request vector, issue feedback,
//         wf_valid / wf_chosen / issue_ack)
module alu_class_wf_arbiter #(
  parameter int NUM_WF       = 40,
  parameter int WF_ID_LENGTH = 6,
  parameter int LOCKOUT      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_class_wf_arbiter_if.slave arb
);

  localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  typedef logic [WF_ID_LENGTH-1:0] wfid_t;

  logic          r_valid;
  wfid_t         r_chosen;
  wfid_t         r_ptr;
  logic [LW-1:0] r_lock [NUM_WF];

  logic              w_issue_hit;
  wfid_t             w_ptr_next;
  logic [NUM_WF-1:0] w_elig;
  logic              w_hold;
  logic              w_found_hi;
  logic              w_found_lo;
  wfid_t             w_pick_hi;
  wfid_t             w_pick_lo;
  logic              w_found;
  wfid_t             w_pick;

  assign w_issue_hit = r_valid & arb.c_issued_valid & arb.class_selected &
                       (arb.c_issued_wfid == r_chosen);

  // The pointer only advances on an accepted issue, never on a plain pick.
  assign w_ptr_next = w_issue_hit ? r_chosen : r_ptr;

  always_comb begin
    w_elig = '0;
    w_hold = 1'b0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      w_elig[i] = arb.req_valid[i] & (r_lock[i] == '0) &
                  ~(w_issue_hit & (wfid_t'(i) == r_chosen));
      if (wfid_t'(i) == r_chosen) begin
        w_hold = r_valid & ~w_issue_hit & w_elig[i];
      end
    end
  end

  // Cyclic search starting at ptr_next+1, split into two ascending scans:
  // the lowest eligible slot above the pointer wins; otherwise the lowest
  // eligible slot at or below it (the wrapped part of the search).
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      if (w_elig[i]) begin
        if (wfid_t'(i) > w_ptr_next) begin
          if (!w_found_hi) begin
            w_found_hi = 1'b1;
            w_pick_hi  = wfid_t'(i);
          end
        end else if (!w_found_lo) begin
          w_found_lo = 1'b1;
          w_pick_lo  = wfid_t'(i);
        end
      end
    end
    w_found = w_found_hi | w_found_lo;
    w_pick  = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_chosen <= '0;
      r_ptr    <= wfid_t'(NUM_WF - 1);
      for (int unsigned i = 0; i < NUM_WF; i++) begin
        r_lock[i] <= '0;
      end
    end else begin
      r_ptr <= w_ptr_next;
      if (w_hold) begin
        r_valid <= 1'b1;
      end else if (w_found) begin
        r_valid  <= 1'b1;
        r_chosen <= w_pick;
      end else begin
        r_valid <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_WF; i++) begin
        if (w_issue_hit && (wfid_t'(i) == r_chosen)) begin
          r_lock[i] <= LW'(LOCKOUT);
        end else if (r_lock[i] != '0) begin
          r_lock[i] <= r_lock[i] - LW'(1);
        end
      end
    end
  end

  assign arb.wf_valid  = r_valid;
  assign arb.wf_chosen = r_chosen;
  assign arb.issue_ack = w_issue_hit;

endmodule

// File: tb/tb_alu_class_wf_arbiter.sv
// Bench for alu_class_wf_arbiter: three instances with LOCKOUT = 0, 2, 7,
// a cycle-based reference model (eligibility from the cycle of the last
// issue, cyclic search by modulo arithmetic) compared every cycle, and
// directed sequences with hand-computed literal expectations.
module tb_alu_class_wf_arbiter;

  localparam int NUM_WF = 40;
  localparam int WL     = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n [3];
  logic [NUM_WF-1:0] req   [3];
  logic              csel  [3];
  logic              iv    [3];
  logic [WL-1:0]     iwfid [3];
  logic              o_val [3];
  logic [WL-1:0]     o_ch  [3];
  logic              o_ack [3];

  int n_vec = 0;
  int n_err = 0;

  alu_class_wf_arbiter_if #(.NUM_WF(NUM_WF), .WF_ID_LENGTH(WL)) bus0 ();
  alu_class_wf_arbiter_if #(.NUM_WF(NUM_WF), .WF_ID_LENGTH(WL)) bus1 ();
  alu_class_wf_arbiter_if #(.NUM_WF(NUM_WF), .WF_ID_LENGTH(WL)) bus2 ();

  assign bus0.req_valid = req[0];  assign bus0.class_selected = csel[0];
  assign bus0.c_issued_valid = iv[0];  assign bus0.c_issued_wfid = iwfid[0];
  assign bus1.req_valid = req[1];  assign bus1.class_selected = csel[1];
  assign bus1.c_issued_valid = iv[1];  assign bus1.c_issued_wfid = iwfid[1];
  assign bus2.req_valid = req[2];  assign bus2.class_selected = csel[2];
  assign bus2.c_issued_valid = iv[2];  assign bus2.c_issued_wfid = iwfid[2];

  assign o_val[0] = bus0.wf_valid;  assign o_ch[0] = bus0.wf_chosen;  assign o_ack[0] = bus0.issue_ack;
  assign o_val[1] = bus1.wf_valid;  assign o_ch[1] = bus1.wf_chosen;  assign o_ack[1] = bus1.issue_ack;
  assign o_val[2] = bus2.wf_valid;  assign o_ch[2] = bus2.wf_chosen;  assign o_ack[2] = bus2.issue_ack;

  alu_class_wf_arbiter #(.NUM_WF(NUM_WF), .WF_ID_LENGTH(WL), .LOCKOUT(0))
    dut0 (.clk(clk), .rst(rst_n[0]), .arb(bus0));
  alu_class_wf_arbiter #(.NUM_WF(NUM_WF), .WF_ID_LENGTH(WL), .LOCKOUT(2))
    dut1 (.clk(clk), .rst(rst_n[1]), .arb(bus1));
  alu_class_wf_arbiter #(.NUM_WF(NUM_WF), .WF_ID_LENGTH(WL), .LOCKOUT(7))
    dut2 (.clk(clk), .rst(rst_n[2]), .arb(bus2));

  function automatic int lk(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 7);
  endfunction

  task automatic check(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  int last_iss [3][NUM_WF];
  bit m_val  [3];
  int m_ch   [3];
  int m_ptr  [3];
  bit m_live [3] = '{0, 0, 0};

  function automatic bit m_elig(input int k, input int i);
    return req[k][i] && (cyc > last_iss[k][i] + lk(k));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n[k] !== 1'b1) begin
        m_val[k]  = 1'b0;
        m_ch[k]   = 0;
        m_ptr[k]  = NUM_WF - 1;
        m_live[k] = 1'b1;
        for (int i = 0; i < NUM_WF; i++) last_iss[k][i] = -1000;
      end else if (m_live[k]) begin
        bit hit;
        bit done;
        hit = m_val[k] && iv[k] && csel[k] && (int'(iwfid[k]) == m_ch[k]);
        if (hit) begin
          last_iss[k][m_ch[k]] = cyc;
          m_ptr[k] = m_ch[k];
        end
        if (!(m_val[k] && !hit && m_elig(k, m_ch[k]))) begin
          done = 1'b0;
          for (int j = 1; j <= NUM_WF; j++) begin
            int s;
            s = (m_ptr[k] + j) % NUM_WF;
            if (!done && m_elig(k, s)) begin
              done = 1'b1;
              m_ch[k] = s;
            end
          end
          m_val[k] = done;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_live[k]) begin
        check("model_valid", k, 32'(o_val[k]), 32'(m_val[k]));
        check("model_chosen", k, 32'(o_ch[k]), m_ch[k]);
        check("model_ack", k, 32'(o_ack[k]),
              32'(m_val[k] && iv[k] && csel[k] && (int'(iwfid[k]) == m_ch[k])));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int rr_exp [5] = '{3, 7, 39, 3, 7};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int k);
    csel[k] = 1'b0; iv[k] = 1'b0; iwfid[k] = '0;
  endtask

  task automatic issue(input int k, input int id);
    csel[k] = 1'b1; iv[k] = 1'b1; iwfid[k] = WL'(id);
  endtask

  task automatic chk_out(input string nm, input int k, input int ev, input int ec);
    check({nm, "_valid"}, k, 32'(o_val[k]), ev);
    check({nm, "_chosen"}, k, 32'(o_ch[k]), ec);
  endtask

  task automatic chk_ack(input string nm, input int k, input int ea);
    #1;
    check(nm, k, 32'(o_ack[k]), ea);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      req[k]   = '0;
      idle(k);
    end

    // reset with every request high
    req[0] = '1;
    tick(); chk_out("rst_hold0", 0, 0, 0);
    tick(); chk_out("rst_hold1", 0, 0, 0);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    tick(); chk_out("rst_release", 0, 1, 0);

    // round robin with wrap, LOCKOUT=0, every candidate accepted
    req[0] = '0; req[0][3] = 1'b1; req[0][7] = 1'b1; req[0][39] = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) begin
      chk_out("rr", 0, 1, rr_exp[j]);
      issue(0, m_ch[0]);
      chk_ack("rr_ack", 0, 1);
      tick();
    end
    idle(0); req[0] = '0;

    // hold then drop, LOCKOUT=2
    req[1] = '0; req[1][5] = 1'b1; req[1][9] = 1'b1;
    tick(); chk_out("hold_first", 1, 1, 5);
    repeat (4) begin tick(); chk_out("hold", 1, 1, 5); end
    req[1][5] = 1'b0;
    tick(); chk_out("drop", 1, 1, 9);

    // lockout window
    req[1] = '0; req[1][12] = 1'b1;
    tick(); chk_out("lk_pick", 1, 1, 12);
    issue(1, 12); chk_ack("lk_ack", 1, 1);
    tick(); idle(1); chk_out("lk_t1", 1, 0, 12);
    tick(); chk_out("lk_t2", 1, 0, 12);
    tick(); chk_out("lk_t3", 1, 0, 12);
    tick(); chk_out("lk_t4", 1, 1, 12);

    // ignored issues: wrong wfid, then class not selected
    req[1] = '0; req[1][20] = 1'b1;
    tick(); chk_out("ign_pick", 1, 1, 20);
    issue(1, 21); chk_ack("ign_wfid_ack", 1, 0);
    tick(); chk_out("ign_wfid", 1, 1, 20);
    issue(1, 20); csel[1] = 1'b0; chk_ack("ign_sel_ack", 1, 0);
    tick(); chk_out("ign_sel", 1, 1, 20);
    idle(1);
    req[1] = '0; req[1][13] = 1'b1; req[1][21] = 1'b1;
    tick(); chk_out("ign_ptr", 1, 1, 13);
    req[1] = '0; req[1][20] = 1'b1;
    tick(); chk_out("ign_lock", 1, 1, 20);
    req[1] = '0;

    // reset mid-operation clears locks, LOCKOUT=7
    req[2] = '0; req[2][4] = 1'b1;
    tick(); chk_out("mr_pick", 2, 1, 4);
    issue(2, 4); chk_ack("mr_ack", 2, 1);
    tick(); idle(2); chk_out("mr_mask", 2, 0, 4);
    rst_n[2] = 1'b0;
    tick(); chk_out("mr_rst", 2, 0, 0);
    rst_n[2] = 1'b1;
    tick(); chk_out("mr_after", 2, 1, 4);
    req[2] = '0;

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
